// File: rtl/minirv_mc_controller.sv
// minirv_mc_controller: multi-cycle RV32I control FSM; define ILLEGAL_TRAP_EN to trap illegal opcodes
module minirv_mc_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [31:0] pc,
  input  logic [31:0] pc_target,
  input  logic        branch_taken,
  output logic        alu_en,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [2:0]  state,
  output logic [31:0] retired,
  output logic        illegal
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, ret_q, ret_d, pc_inc;
  logic [6:0]  op;
  logic        is_r, is_imm, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc, legal;
  assign op        = ir_q[6:0];
  assign is_r      = op == 7'b0110011;
  assign is_imm    = op == 7'b0010011;
  assign is_load   = op == 7'b0000011;
  assign is_store  = op == 7'b0100011;
  assign is_branch = op == 7'b1100011;
  assign is_jal    = op == 7'b1101111;
  assign is_jalr   = op == 7'b1100111;
  assign is_lui    = op == 7'b0110111;
  assign is_auipc  = op == 7'b0010111;
  assign legal     = is_r | is_imm | is_load | is_store | is_branch | is_jal | is_jalr | is_lui | is_auipc;
  assign pc_inc    = pc_q + 32'd4;
  // state, pc, instruction and retire counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ret_q   <= ret_d;
    end
  end
  // next-state, pc update and retirement per instruction class
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ret_d   = ret_q;
    case (state_q)
      FETCH: if (imem_ack) begin
        ir_d    = imem_rdata;
        state_d = DECODE;
      end
      DECODE: if (legal) state_d = EXEC;
      else begin
`ifdef ILLEGAL_TRAP_EN
        state_d = TRAP;
`else
        state_d = FETCH;
        pc_d    = pc_inc;
        ret_d   = ret_q + 32'd1;
`endif
      end
      EXEC: if (is_load | is_store) state_d = MEM;
      else if (is_branch) begin
        state_d = FETCH;
        pc_d    = branch_taken ? pc_target : pc_inc;
        ret_d   = ret_q + 32'd1;
      end else state_d = WB;
      MEM: if (dmem_ack) begin
        state_d = is_store ? FETCH : WB;
        pc_d    = is_store ? pc_inc : pc_q;
        ret_d   = is_store ? ret_q + 32'd1 : ret_q;
      end
      WB: begin
        state_d = FETCH;
        pc_d    = (is_jal | is_jalr) ? pc_target : pc_inc;
        ret_d   = ret_q + 32'd1;
      end
      TRAP: state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end
  assign imem_req  = rst_n & (state_q == FETCH);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign alu_en    = state_q == EXEC;
  assign dmem_req  = state_q == MEM;
  assign dmem_we   = (state_q == MEM) & is_store;
  assign rf_we     = (state_q == WB) & (ir_q[11:7] != 5'd0);
  assign state     = state_q;
  assign retired   = ret_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegal   = state_q == TRAP;
`else
  assign illegal   = 1'b0;
`endif
endmodule

// File: tb/tb_minirv_mc_controller.sv
// tb_minirv_mc_controller: directed vector bench for the multi-cycle controller
module tb_minirv_mc_controller;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_req, imem_ack, alu_en, dmem_req, dmem_we, dmem_ack, rf_we, branch_taken, illegal;
  logic [31:0] imem_addr, imem_rdata, ir, pc, pc_target, retired;
  logic [2:0]  state;
  int          errs = 0, checks = 0;

  minirv_mc_controller dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ir(ir), .pc(pc), .pc_target(pc_target), .branch_taken(branch_taken),
    .alu_en(alu_en), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .rf_we(rf_we),
    .state(state), .retired(retired), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr, tgt;
    logic        taken;
    int          dly, cyc;
    logic [31:0] pc, ret;
    int          rf, dm;
    logic        dmw;
    int          alu;
  } vec_t;
  vec_t v[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t t, input string name);
    int   cyc = 0, rf = 0, dm = 0, alu = 0, wt = 0, bad = 0;
    logic dmw = 1'b0;
    imem_rdata   = t.instr;
    pc_target    = t.tgt;
    branch_taken = t.taken;
    imem_ack     = 1'b1;
    do begin
      cyc++;
      rf  += int'(rf_we);
      dm  += int'(dmem_req);
      alu += int'(alu_en);
      dmw |= dmem_we;
      if (int'(imem_req) + int'(alu_en) + int'(dmem_req) + int'(rf_we) > 1) bad++;
      dmem_ack = dmem_req && (wt >= t.dly);
      if (dmem_req) wt++;
      @(negedge clk);
    end while (state != 3'd0 && cyc < 40);
    dmem_ack = 1'b0;
    chk({name, " cycles"}, cyc, t.cyc);
    chk({name, " pc"}, pc, t.pc);
    chk({name, " imem_addr"}, imem_addr, t.pc);
    chk({name, " retired"}, retired, t.ret);
    chk({name, " rf_we cycles"}, rf, t.rf);
    chk({name, " dmem_req cycles"}, dm, t.dm);
    chk({name, " dmem_we"}, {31'd0, dmw}, {31'd0, t.dmw});
    chk({name, " alu_en cycles"}, alu, t.alu);
    chk({name, " strobe overlap"}, bad, 0);
    chk({name, " illegal"}, {31'd0, illegal}, 32'd0);
  endtask

  initial begin
    logic [31:0] pc_hold;
    int          n;
    v[0]  = '{32'h003100B3, 32'hDEADBEE0, 1'b0, 0, 4, 32'h0000_0004, 32'd1,  1, 0, 1'b0, 1};
    v[1]  = '{32'h0000A283, 32'hDEADBEE0, 1'b0, 3, 8, 32'h0000_0008, 32'd2,  1, 4, 1'b0, 1};
    v[2]  = '{32'h0050A223, 32'hDEADBEE0, 1'b0, 1, 5, 32'h0000_000C, 32'd3,  0, 2, 1'b1, 1};
    v[3]  = '{32'h00000063, 32'h0000_0100, 1'b1, 0, 3, 32'h0000_0100, 32'd4,  0, 0, 1'b0, 1};
    v[4]  = '{32'h00000063, 32'h0000_0080, 1'b1, 0, 3, 32'h0000_0080, 32'd5,  0, 0, 1'b0, 1};
    v[5]  = '{32'h000000EF, 32'h0000_0100, 1'b0, 0, 4, 32'h0000_0100, 32'd6,  1, 0, 1'b0, 1};
    v[6]  = '{32'h00000063, 32'h0000_0080, 1'b0, 0, 3, 32'h0000_0104, 32'd7,  0, 0, 1'b0, 1};
    v[7]  = '{32'h00008067, 32'hFFFF_FFFC, 1'b0, 0, 4, 32'hFFFF_FFFC, 32'd8,  0, 0, 1'b0, 1};
    v[8]  = '{32'h00000013, 32'hDEADBEE0, 1'b0, 0, 4, 32'h0000_0000, 32'd9,  0, 0, 1'b0, 1};
    v[9]  = '{32'h000123B7, 32'hDEADBEE0, 1'b0, 0, 4, 32'h0000_0004, 32'd10, 1, 0, 1'b0, 1};
    v[10] = '{32'h00000417, 32'hDEADBEE0, 1'b0, 0, 4, 32'h0000_0008, 32'd11, 1, 0, 1'b0, 1};
    imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0; pc_target = '0; branch_taken = 1'b0;
    #12;
    chk("reset state", {29'd0, state}, 32'd0);
    chk("reset pc", pc, 32'h0);
    chk("reset ir", ir, 32'h0);
    chk("reset retired", retired, 32'h0);
    chk("reset imem_req", {31'd0, imem_req}, 32'd0);
    chk("reset illegal", {31'd0, illegal}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("first fetch imem_req", {31'd0, imem_req}, 32'd1);
    imem_rdata = 32'h003100B3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d state", i), {29'd0, state}, 32'd0);
      chk($sformatf("stall%0d pc", i), pc, 32'h0);
      chk($sformatf("stall%0d ir", i), ir, 32'h0);
      chk($sformatf("stall%0d imem_req", i), {31'd0, imem_req}, 32'd1);
    end
    for (int i = 0; i < 11; i++) run(v[i], $sformatf("v%0d", i));
    imem_rdata = 32'h0000A283;
    imem_ack   = 1'b1;
    n = 0;
    while (state != 3'd3 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("mem reached", {29'd0, state}, 32'd3);
    repeat (2) @(negedge clk);
    chk("mem wait dmem_req", {31'd0, dmem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid-mem rst dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("mid-mem rst state", {29'd0, state}, 32'd0);
    chk("mid-mem rst pc", pc, 32'h0);
    chk("mid-mem rst retired", retired, 32'h0);
    chk("mid-mem rst imem_req", {31'd0, imem_req}, 32'd0);
    chk("mid-mem rst ir", ir, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    imem_rdata = 32'h0000007F;
    #1;
    chk("post-rst imem_addr", imem_addr, 32'h0);
    chk("post-rst imem_req", {31'd0, imem_req}, 32'd1);
    chk("post-rst retired", retired, 32'h0);
`ifdef ILLEGAL_TRAP_EN
    n = 0;
    while (state != 3'd5 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("trap state", {29'd0, state}, 32'd5);
    chk("trap illegal", {31'd0, illegal}, 32'd1);
    pc_hold = pc;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("trap%0d imem_req", i), {31'd0, imem_req}, 32'd0);
      chk($sformatf("trap%0d strobes", i), {29'd0, alu_en, dmem_req, rf_we}, 32'd0);
      chk($sformatf("trap%0d pc", i), pc, pc_hold);
      chk($sformatf("trap%0d retired", i), retired, 32'h0);
      chk($sformatf("trap%0d state", i), {29'd0, state}, 32'd5);
    end
`else
    pc_hold = 32'h0;
    run('{32'h0000007F, 32'hDEADBEE0, 1'b0, 0, 2, 32'h0000_0004, 32'd1, 0, 0, 1'b0, 0}, "illegal-nop");
    chk("illegal-nop pc advance", pc - pc_hold, 32'd4);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
